// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs field requests into 32-bit words, range-checks
// the immediate, buffers legal words and streams them to consecutive IM addresses.
module inst_encoder #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_FMT
  } err_e;

  logic signed [31:0] simm;
  logic [31:0]        enc_word;
  err_e               enc_code;

  logic [31:0]      buf_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             full;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop;

  assign simm = imm;

  // Field packing and immediate legality; range violations take precedence over alignment.
  always_comb begin
    enc_word = 32'd0;
    enc_code = ERR_NONE;
    case (fmt_e'(fmt))
      FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        if (simm < -32'sd2048 || simm > 32'sd2047) enc_code = ERR_RANGE;
      end
      FMT_SH: begin
        enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        if (simm < 32'sd0 || simm > 32'sd31) enc_code = ERR_RANGE;
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (simm < -32'sd2048 || simm > 32'sd2047) enc_code = ERR_RANGE;
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (simm < -32'sd4096 || simm > 32'sd4094) enc_code = ERR_RANGE;
        else if (imm[0])                           enc_code = ERR_ALIGN;
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'd0) enc_code = ERR_RANGE;
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (simm < -32'sd1048576 || simm > 32'sd1048574) enc_code = ERR_RANGE;
        else if (imm[0])                                 enc_code = ERR_ALIGN;
      end
      default: enc_code = ERR_FMT;
    endcase
  end

  // Full blocks acceptance even when a pop happens the same cycle.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign in_ready = rstn && !full && !start;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (enc_code == ERR_NONE);
  assign pop      = !empty && mem_ready && !start;

  assign im_we    = !empty;
  assign im_wdata = buf_mem[rd_ptr[PTR_W-1:0]];

  // Buffer, write address, counters and sticky error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) buf_mem[i] <= 32'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      im_addr  <= ADDR_W'(BASE_ADDR);
      count    <= '0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      im_addr  <= ADDR_W'(BASE_ADDR);
      count    <= '0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
        im_addr <= im_addr + ADDR_W'(1);
        if (count != {(ADDR_W+1){1'b1}}) count <= count + (ADDR_W+1)'(1);
      end
      if (accept && enc_code != ERR_NONE) begin
        err <= 1'b1;
        if (!err) err_code <= enc_code;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed bench for inst_encoder against a queue-based reference
// model; a second instance with a 2-bit address exercises address wrap.
module tb_inst_encoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        mem_ready = 1'b0;

  logic        in_ready, im_we, err;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic [1:0]  err_code;
  logic [8:0]  count;

  logic        s_in_ready, s_im_we, s_err;
  logic [1:0]  s_im_addr;
  logic [31:0] s_im_wdata;
  logic [1:0]  s_err_code;
  logic [2:0]  s_count;

  int n_checks = 0;
  int n_fail = 0;
  logic mr_rand = 1'b0;
  logic mr_force = 1'b1;

  // Reference model state.
  logic [31:0] q[$];
  int maddr = 0, mcount = 0, mcode = 0;
  logic merr = 1'b0;
  logic [31:0] wlog_d[$];
  int wlog_a[$], slog_a[$];

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(8), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .mem_ready(mem_ready),
    .err(err), .err_code(err_code), .count(count));

  inst_encoder #(.ADDR_W(2), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0)) u_small (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .im_we(s_im_we), .im_addr(s_im_addr), .im_wdata(s_im_wdata), .mem_ready(mem_ready),
    .err(s_err), .err_code(s_err_code), .count(s_count));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Encoding from the instruction-format bit placement, using shifts and masks.
  function automatic void ref_encode(input int unsigned f, input int unsigned op,
      input int unsigned f3, input int unsigned f7, input int unsigned r_d,
      input int unsigned r_s1, input int unsigned r_s2, input int im,
      output logic [31:0] w, output int code);
    int unsigned u;
    int unsigned base;
    u = im;
    base = (r_s1 << 15) | (f3 << 12) | op;
    code = 0;
    w = 32'd0;
    case (f)
      0: w = (f7 << 25) | (r_s2 << 20) | base | (r_d << 7);
      1: begin
        w = ((u & 32'hfff) << 20) | base | (r_d << 7);
        if (im < -2048 || im > 2047) code = 1;
      end
      2: begin
        w = (f7 << 25) | ((u & 31) << 20) | base | (r_d << 7);
        if (im < 0 || im > 31) code = 1;
      end
      3: begin
        w = (((u >> 5) & 127) << 25) | (r_s2 << 20) | base | ((u & 31) << 7);
        if (im < -2048 || im > 2047) code = 1;
      end
      4: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (r_s2 << 20) | base |
            (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7);
        if (im < -4096 || im > 4094) code = 1;
        else if ((u & 1) != 0) code = 2;
      end
      5: begin
        w = (u & 32'hfffff000) | (r_d << 7) | op;
        if ((u & 32'hfff) != 0) code = 1;
      end
      6: begin
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 255) << 12) | (r_d << 7) | op;
        if (im < -1048576 || im > 1048574) code = 1;
        else if ((u & 1) != 0) code = 2;
      end
      default: code = 3;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    mem_ready = mr_rand ? 1'($urandom_range(0, 1)) : mr_force;
  end

  // Scoreboard: compares outputs with model state, then predicts the next edge.
  logic        exp_ready;
  logic [31:0] m_w;
  int          m_code;
  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_im_we", 32'(im_we), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_s_im_we", 32'(s_im_we), 32'd0);
      q.delete();
      maddr = 0; mcount = 0; merr = 1'b0; mcode = 0;
    end else begin
      exp_ready = !start && (q.size() < DEPTH);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("im_we", 32'(im_we), 32'(q.size() != 0));
      check("im_addr", 32'(im_addr), 32'(maddr));
      if (q.size() != 0) check("im_wdata", im_wdata, q[0]);
      check("err", 32'(err), 32'(merr));
      check("err_code", 32'(err_code), 32'(mcode));
      check("count", 32'(count), 32'(mcount));
      check("s_im_we", 32'(s_im_we), 32'(q.size() != 0));
      check("s_im_addr", 32'(s_im_addr), 32'(maddr % 4));
      check("s_count", 32'(s_count), 32'((mcount > 7) ? 7 : mcount));
      if (start) begin
        q.delete();
        maddr = 0; mcount = 0; merr = 1'b0; mcode = 0;
      end else begin
        if (q.size() != 0 && mem_ready) begin
          wlog_a.push_back(int'(im_addr));
          wlog_d.push_back(im_wdata);
          slog_a.push_back(int'(s_im_addr));
          void'(q.pop_front());
          maddr = (maddr + 1) % 256;
          if (mcount < 511) mcount++;
        end
        if (in_valid && exp_ready) begin
          ref_encode(32'(fmt), 32'(opcode), 32'(funct3), 32'(funct7), 32'(rd),
                     32'(rs1), 32'(rs2), int'(imm), m_w, m_code);
          if (m_code == 0) q.push_back(m_w);
          else begin
            if (!merr) mcode = m_code;
            merr = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int f, input int op, input int f3, input int f7,
      input int r_d, input int r_s1, input int r_s2, input int im);
    fmt = 3'(f); opcode = 7'(op); funct3 = 3'(f3); funct7 = 7'(f7);
    rd = 5'(r_d); rs1 = 5'(r_s1); rs2 = 5'(r_s2); imm = 32'(im);
    in_valid = 1'b1;
  endtask

  // Present a request and hold it until the edge that accepts it.
  task automatic send(input int f, input int op, input int f3, input int f7,
      input int r_d, input int r_s1, input int r_s2, input int im);
    logic ok;
    set_req(f, op, f3, f7, r_d, r_s1, r_s2, im);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic start_pulse();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    idle();
    mr_rand = 1'b0;
    mr_force = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!im_we) break;
    end
    check("drain", 32'(im_we), 32'd0);
    tick();
  endtask

  function automatic int rand_imm();
    int bnd[18] = '{-2048, 2047, 2048, -2049, 0, 31, 32, -1, -4096, 4094, 4095, -4097,
                    -1048576, 1048574, 1048575, -1048577, 1048576, 4096};
    int r;
    case ($urandom_range(0, 4))
      0: r = int'($urandom_range(0, 63)) - 32;
      1: r = bnd[$urandom_range(0, 17)];
      2: r = int'($urandom);
      3: r = int'($urandom_range(0, 4095)) - 2048;
      default: r = int'($urandom & 32'hfffff000);
    endcase
    return r;
  endfunction

  int st_f[6]  = '{0, 3, 4, 6, 2, 5};
  int st_op[6] = '{'h33, 'h23, 'h63, 'h6f, 'h13, 'h37};
  int st_f3[6] = '{0, 2, 0, 0, 5, 0};
  int st_f7[6] = '{0, 0, 0, 0, 'h20, 0};
  int st_rd[6] = '{3, 0, 0, 1, 4, 5};
  int st_r1[6] = '{1, 1, 1, 0, 1, 0};
  int st_r2[6] = '{2, 2, 2, 0, 0, 0};
  int st_im[6] = '{0, 4, 8, 16, 3, 'h12345000};
  logic [31:0] st_exp[6] = '{32'h002081B3, 32'h0020A223, 32'h00208463,
                             32'h010000EF, 32'h4030D213, 32'h123452B7};
  int base;

  initial begin
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_im_we", 32'(im_we), 32'd0);
    check("reset_im_addr", 32'(im_addr), 32'd0);
    check("reset_im_wdata", im_wdata, 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_err_code", 32'(err_code), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // addi x1,x0,5
    base = wlog_d.size();
    send(1, 'h13, 0, 0, 1, 0, 0, 5);
    drain();
    check("addi_nwrites", 32'(wlog_d.size() - base), 32'd1);
    check("addi_addr", 32'(wlog_a[base]), 32'd0);
    check("addi_data", wlog_d[base], 32'h00500093);
    check("addi_count", 32'(count), 32'd1);

    // Back-to-back stream with memory always ready
    start_pulse();
    base = wlog_d.size();
    for (int i = 0; i < 6; i++)
      send(st_f[i], st_op[i], st_f3[i], st_f7[i], st_rd[i], st_r1[i], st_r2[i], st_im[i]);
    drain();
    check("stream_nwrites", 32'(wlog_d.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("stream_addr", 32'(wlog_a[base + i]), 32'(i));
      check("stream_data", wlog_d[base + i], st_exp[i]);
    end

    // Memory stalled: buffer fills, outputs hold
    start_pulse();
    mr_force = 1'b0;
    tick();
    base = wlog_d.size();
    for (int i = 0; i < 4; i++)
      send(st_f[i], st_op[i], st_f3[i], st_f7[i], st_rd[i], st_r1[i], st_r2[i], st_im[i]);
    set_req(st_f[4], st_op[4], st_f3[4], st_f7[4], st_rd[4], st_r1[4], st_r2[4], st_im[4]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_im_we", 32'(im_we), 32'd1);
      check("stall_im_addr", 32'(im_addr), 32'd0);
      check("stall_im_wdata", im_wdata, st_exp[0]);
    end
    tick();
    mr_force = 1'b1;
    for (int i = 4; i < 6; i++)
      send(st_f[i], st_op[i], st_f3[i], st_f7[i], st_rd[i], st_r1[i], st_r2[i], st_im[i]);
    drain();
    check("stall_nwrites", 32'(wlog_d.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("stall_addr", 32'(wlog_a[base + i]), 32'(i));
      check("stall_data", wlog_d[base + i], st_exp[i]);
    end

    // Error capture and sticky first code
    start_pulse();
    base = wlog_d.size();
    send(1, 'h13, 0, 0, 1, 0, 0, 2048);
    drain();
    check("i2048_err", 32'(err), 32'd1);
    check("i2048_code", 32'(err_code), 32'd1);
    check("i2048_nowrite", 32'(wlog_d.size() - base), 32'd0);
    send(4, 'h63, 0, 0, 0, 1, 2, 7);
    drain();
    check("b7_code_sticky", 32'(err_code), 32'd1);
    start_pulse();
    check("start_err", 32'(err), 32'd0);
    check("start_addr", 32'(im_addr), 32'd0);
    send(4, 'h63, 0, 0, 0, 1, 2, 6);
    drain();
    check("b6_legal_err", 32'(err), 32'd0);
    check("b6_data", wlog_d[wlog_d.size() - 1], 32'h00208363);
    send(4, 'h63, 0, 0, 0, 1, 2, 5);
    drain();
    check("b5_code", 32'(err_code), 32'd2);
    send(7, 'h13, 0, 0, 1, 0, 0, 0);
    drain();
    check("fmt7_after_code2", 32'(err_code), 32'd2);
    start_pulse();
    send(7, 'h13, 0, 0, 1, 0, 0, 0);
    base = wlog_d.size();
    send(1, 'h13, 0, 0, 1, 0, 0, 5);
    drain();
    check("fmt7_code", 32'(err_code), 32'd3);
    check("after_err_write", 32'(wlog_d.size() - base), 32'd1);
    check("after_err_addr", 32'(wlog_a[base]), 32'd0);
    check("after_err_data", wlog_d[base], 32'h00500093);

    // Address wrap on the narrow instance
    start_pulse();
    base = slog_a.size();
    for (int i = 0; i < 5; i++) send(1, 'h13, 0, 0, i + 1, 0, 0, i);
    drain();
    for (int i = 0; i < 5; i++) check("wrap_addr", 32'(slog_a[base + i]), 32'(i % 4));
    check("wrap_count", 32'(s_count), 32'd5);

    // Reset mid-stream discards pending words
    mr_force = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) send(0, 'h33, 0, 0, 1, 2, 3, 0);
    idle();
    base = wlog_d.size();
    rstn = 1'b0;
    #1;
    check("midrst_im_we", 32'(im_we), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_s_im_we", 32'(s_im_we), 32'd0);
    check("midrst_s_count", 32'(s_count), 32'd0);
    tick(); tick();
    rstn = 1'b1;
    mr_force = 1'b1;
    repeat (5) tick();
    check("midrst_nowrite", 32'(wlog_d.size() - base), 32'd0);
    check("midrst_after_we", 32'(im_we), 32'd0);

    // Random traffic with random memory backpressure
    mr_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) start_pulse();
      if ($urandom_range(0, 5) == 0) begin idle(); tick(); end
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), rand_imm());
    end
    drain();
    check("final_model_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
